pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RISC-V pipeline. It combines the load-use hazard check, taken-branch redirect, data-memory wait handshake and multi-cycle mul/div busy into one set of per-register enables and flushes. It tracks long waits in a small state machine with a watchdog and counts stalled cycles for performance monitoring. It sits beside the pipeline registers and drives every PC/IF-ID/ID-EX/EX-MEM/MEM-WB write enable.

---
 rtl/pipeline_stall_ctrl_if.sv | 47 ++++
 rtl/pipeline_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl_if
// Purpose  : Hazard inputs and per-register enable/flush outputs of the
//            pipeline stall/flush controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_stall_ctrl_if #(
    parameter int REG_NUM_BITWIDTH = 5
);
    logic                        id_memRead;
    logic [REG_NUM_BITWIDTH-1:0] id_Rd;
    logic [REG_NUM_BITWIDTH-1:0] if_Rs1;
    logic [REG_NUM_BITWIDTH-1:0] if_Rs2;
    logic                        ex_branchTaken;
    logic                        mem_req;
    logic                        mem_ready;
    logic                        ex_mdOp;
    logic                        md_done;

    logic                        pc_en;
    logic                        ifid_en;
    logic                        idex_en;
    logic                        exmem_en;
    logic                        memwb_en;
    logic                        ifid_flush;
    logic                        idex_flush;
    logic                        exmem_flush;

    // Pipeline side: reports hazards, consumes enables and flushes.
    modport master (
        output id_memRead, id_Rd, if_Rs1, if_Rs2, ex_branchTaken,
               mem_req, mem_ready, ex_mdOp, md_done,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush
    );

    // Controller side.
    modport slave (
        input  id_memRead, id_Rd, if_Rs1, if_Rs2, ex_branchTaken,
               mem_req, mem_ready, ex_mdOp, md_done,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Purpose  : Central stall/flush controller for the 5-stage pipeline with
//            freeze watchdog and stalled-cycle performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int TIMEOUT_CYC  = 1024,
    parameter int CNT_BITWIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    pipeline_stall_ctrl_if.slave         io_pipe,
    input  wire logic                    i_perf_clr,
    output logic                         o_err,
    output logic [CNT_BITWIDTH-1:0]      o_stall_cnt
);

    localparam int                      c_WAIT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [c_WAIT_W-1:0]     c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_WAIT_W-1:0]     c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [CNT_BITWIDTH-1:0] c_CNT_ONE   = CNT_BITWIDTH'(1);
    localparam logic [CNT_BITWIDTH-1:0] c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_MD_WAIT  = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_WAIT_W-1:0]     r_wait_cnt;
    logic [CNT_BITWIDTH-1:0] r_stall_cnt;
    logic                    r_err;

    logic w_memfrz;
    logic w_mdfrz;
    logic w_frozen;
    logic w_branch;
    logic w_loaduse;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;

    assign w_memfrz  = io_pipe.mem_req & ~io_pipe.mem_ready;
    assign w_mdfrz   = io_pipe.ex_mdOp & ~io_pipe.md_done;
    assign w_frozen  = w_memfrz | w_mdfrz;
    assign w_branch  = io_pipe.ex_branchTaken;
    assign w_loaduse = io_pipe.id_memRead && (io_pipe.id_Rd != '0) &&
                       ((io_pipe.id_Rd == io_pipe.if_Rs1) ||
                        (io_pipe.id_Rd == io_pipe.if_Rs2));

    // Wait states differ from RUN only in bookkeeping; the same priority
    // chain drives the enables in RUN, MEM_WAIT and MD_WAIT.
    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        if (!rst_n || (r_state == S_ERR) || w_memfrz) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_memwb_en = 1'b0;
        end else if (w_mdfrz) begin
            // Older instructions drain through MEM/WB behind a bubble.
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
        end else if (w_branch) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_loaduse) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (i_perf_clr) begin
                r_stall_cnt <= '0;
            end else if (!w_pc_en && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end

            case (r_state)
                S_ERR: begin
                    r_err      <= 1'b1;
                    r_wait_cnt <= '0;
                end
                default: begin
                    if (w_frozen) begin
                        // r_wait_cnt holds earlier frozen cycles of this run.
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_wait_cnt <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                            r_state    <= w_memfrz ? S_MEM_WAIT : S_MD_WAIT;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                        r_state    <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign io_pipe.pc_en       = w_pc_en;
    assign io_pipe.ifid_en     = w_ifid_en;
    assign io_pipe.idex_en     = w_idex_en;
    assign io_pipe.exmem_en    = w_exmem_en;
    assign io_pipe.memwb_en    = w_memwb_en;
    assign io_pipe.ifid_flush  = w_ifid_flush;
    assign io_pipe.idex_flush  = w_idex_flush;
    assign io_pipe.exmem_flush = w_exmem_flush;

    assign o_err       = r_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Purpose  : Self-checking bench for pipeline_stall_ctrl (vector table,
//            corner sequences, randomized run against a cycle model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 6;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Output order: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
    localparam logic [7:0] P_DEF = 8'b11111_000;
    localparam logic [7:0] P_MEM = 8'b00000_000;
    localparam logic [7:0] P_MD  = 8'b00011_001;
    localparam logic [7:0] P_BR  = 8'b11111_110;
    localparam logic [7:0] P_LU  = 8'b00111_010;
    localparam logic [7:0] P_OFF = 8'b00000_000;

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       mq;
        logic       my;
        logic       md;
        logic       mdd;
        logic       clr;
        logic [7:0] exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             i_perf_clr;
    logic             o_err;
    logic [CNT_W-1:0] o_stall_cnt;

    int n_total;
    int n_bad;

    int m_run;
    bit m_err;
    int m_stall;

    pipeline_stall_ctrl_if #(.REG_NUM_BITWIDTH(5)) pif ();

    pipeline_stall_ctrl #(
        .TIMEOUT_CYC  (TIMEOUT),
        .CNT_BITWIDTH (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io_pipe     (pif),
        .i_perf_clr  (i_perf_clr),
        .o_err       (o_err),
        .o_stall_cnt (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic vec_t mk(int mr, int rd, int rs1, int rs2, int br, int mq,
                                int my, int md, int mdd, int clr, logic [7:0] exp);
        vec_t v;
        v.mr  = 1'(mr);
        v.rd  = 5'(rd);
        v.rs1 = 5'(rs1);
        v.rs2 = 5'(rs2);
        v.br  = 1'(br);
        v.mq  = 1'(mq);
        v.my  = 1'(my);
        v.md  = 1'(md);
        v.mdd = 1'(mdd);
        v.clr = 1'(clr);
        v.exp = exp;
        return v;
    endfunction

    // Reference: strict priority of the four hazard rules.
    function automatic logic [7:0] model_out(vec_t v, bit err);
        if (err)                  return P_OFF;
        if (v.mq && !v.my)        return P_MEM;
        if (v.md && !v.mdd)       return P_MD;
        if (v.br)                 return P_BR;
        if (v.mr && v.rd != 5'd0 && (v.rd == v.rs1 || v.rd == v.rs2))
                                  return P_LU;
        return P_DEF;
    endfunction

    function automatic logic [7:0] dut_out();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        pif.id_memRead     = v.mr;
        pif.id_Rd          = v.rd;
        pif.if_Rs1         = v.rs1;
        pif.if_Rs2         = v.rs2;
        pif.ex_branchTaken = v.br;
        pif.mem_req        = v.mq;
        pif.mem_ready      = v.my;
        pif.ex_mdOp        = v.md;
        pif.md_done        = v.mdd;
        i_perf_clr         = v.clr;
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    task automatic model_step(input vec_t v);
        logic [7:0] e;
        bit         frz;
        e   = model_out(v, m_err);
        frz = (v.mq && !v.my) || (v.md && !v.mdd);
        if (v.clr)                             m_stall = 0;
        else if (!e[7] && m_stall < CNT_MAX)   m_stall = m_stall + 1;
        if (!m_err) begin
            if (frz) begin
                m_run = m_run + 1;
                if (m_run >= TIMEOUT) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after, model on rise.
    task automatic apply(input vec_t v, input logic [7:0] exp, input string name);
        @(negedge clk);
        drive(v);
        #1;
        chk({name, "_out"}, {24'd0, dut_out()}, {24'd0, exp});
        chk({name, "_err"}, {31'd0, o_err}, {31'd0, m_err});
        chk({name, "_cnt"}, {28'd0, o_stall_cnt}, m_stall);
        @(posedge clk);
        model_step(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_DEF));
        rst_n = 1'b0;
        #1;
        chk("rst_out", {24'd0, dut_out()}, {24'd0, P_OFF});
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_cnt", {28'd0, o_stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tab [16];
    vec_t v;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_DEF));
        model_reset();

        //           mr rd rs1 rs2 br mq my md mdd clr  exp
        tab[0]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 0,  0, P_DEF);
        tab[1]  = mk(1, 5, 5,  2,  0, 0, 0, 0, 0,  0, P_LU);
        tab[2]  = mk(1, 5, 3,  5,  0, 0, 0, 0, 0,  0, P_LU);
        tab[3]  = mk(1, 0, 0,  0,  0, 0, 0, 0, 0,  0, P_DEF);
        tab[4]  = mk(0, 5, 5,  5,  0, 0, 0, 0, 0,  0, P_DEF);
        tab[5]  = mk(1, 5, 3,  4,  0, 0, 0, 0, 0,  0, P_DEF);
        tab[6]  = mk(0, 0, 0,  0,  1, 0, 0, 0, 0,  0, P_BR);
        tab[7]  = mk(1, 7, 7,  0,  1, 0, 0, 0, 0,  0, P_BR);
        tab[8]  = mk(0, 0, 0,  0,  0, 0, 0, 1, 0,  0, P_MD);
        tab[9]  = mk(0, 0, 0,  0,  0, 0, 0, 1, 1,  0, P_DEF);
        tab[10] = mk(0, 0, 0,  0,  1, 0, 0, 1, 0,  0, P_MD);
        tab[11] = mk(0, 0, 0,  0,  0, 1, 0, 0, 0,  0, P_MEM);
        tab[12] = mk(1, 9, 9,  1,  0, 1, 1, 0, 0,  0, P_LU);
        tab[13] = mk(0, 0, 0,  0,  1, 1, 0, 1, 0,  0, P_MEM);
        tab[14] = mk(0, 0, 0,  0,  1, 0, 0, 1, 1,  0, P_BR);
        tab[15] = mk(0, 0, 0,  0,  0, 0, 1, 0, 0,  0, P_DEF);

        do_reset();
        for (int i = 0; i < 16; i++) apply(tab[i], tab[i].exp, $sformatf("tab%0d", i));

        // Load-use: one bubble counted; rd=0 never stalls.
        do_reset();
        apply(mk(1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0), P_LU, "lu");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "lu_x0");
        chk("lu_cnt_one", {28'd0, o_stall_cnt}, 32'd1);

        // Branch outranks a simultaneous load-use and costs no stall.
        do_reset();
        apply(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0), P_BR, "br_lu");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "br_after");
        chk("br_cnt_zero", {28'd0, o_stall_cnt}, 32'd0);

        // Memory wait of 3 cycles, release in the ready cycle.
        do_reset();
        repeat (3) apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), P_MEM, "mw");
        apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), P_DEF, "mw_rel");
        chk("mw_cnt", {28'd0, o_stall_cnt}, 32'd3);

        // Mul/div wait interrupted by a memory freeze on cycle 2.
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), P_MD, "md1");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), P_MEM, "md2");
        repeat (3) apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), P_MD, "md35");
        apply(mk(1, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0), P_LU, "md6");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "md7");
        chk("md_cnt", {28'd0, o_stall_cnt}, 32'd6);
        chk("md_no_err", {31'd0, o_err}, 32'd0);

        // One frozen cycle short of the watchdog limit.
        do_reset();
        repeat (TIMEOUT - 1) apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), P_MEM, "tmo_m1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "tmo_m1_rel");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "tmo_m1_run");
        chk("tmo_m1_err", {31'd0, o_err}, 32'd0);

        // Watchdog: frozen TIMEOUT cycles then sticky ERR.
        do_reset();
        repeat (TIMEOUT) apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), P_MEM, "tmo");
        repeat (3) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_OFF, "err_st");
        chk("err_sticky", {31'd0, o_err}, 32'd1);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_err", {31'd0, o_err}, 32'd0);
        chk("async_cnt", {28'd0, o_stall_cnt}, 32'd0);
        chk("async_out", {24'd0, dut_out()}, {24'd0, P_OFF});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "post_async");

        // Counter saturation and clear priority.
        do_reset();
        repeat (CNT_MAX + 3) apply(mk(1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0), P_LU, "sat");
        chk("sat_hold", {28'd0, o_stall_cnt}, CNT_MAX);
        apply(mk(1, 4, 4, 0, 0, 0, 0, 0, 0, 1, 0), P_LU, "sat_clr");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), P_DEF, "sat_after");
        chk("clr_zero", {28'd0, o_stall_cnt}, 32'd0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = mk(($urandom_range(0, 2) == 0) ? 1 : 0,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   ($urandom_range(0, 2) == 0) ? 1 : 0,
                   ($urandom_range(0, 2) != 0) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   ($urandom_range(0, 1) == 0) ? 1 : 0,
                   ($urandom_range(0, 19) == 0) ? 1 : 0, 0);
            // Bursts of long memory waits drive the watchdog into ERR.
            if ((i % 500) >= 480) v.my = 1'b0;
            apply(v, model_out(v, m_err), "rnd");
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
